// File: rtl/nzp_branch_unit.sv
// Condition-code register and branch resolver for the pipelined LC-3b datapath.
// Holds a branch until every older CC writer has written back, then pulses a registered result.
module nzp_branch_unit #(
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 4,
    parameter int BYPASS   = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cc_issue,
    input  logic                              cc_wb_valid,
    input  logic [DATA_W-1:0]                 cc_wb_data,
    input  logic                              br_valid,
    input  logic [2:0]                        br_nzp,
    output logic                              br_ready,
    output logic                              br_res_valid,
    output logic                              br_taken,
    output logic [2:0]                        cc,
    output logic [$clog2(MAX_PEND+1)-1:0]     pend_cnt,
    output logic                              issue_stall,
    output logic                              err_underflow
);
    localparam int CNT_W = $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PEND);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic [2:0] derive_cc(input logic [DATA_W-1:0] data);
        if (data[DATA_W-1]) begin
            return 3'b100;
        end else if (data == {DATA_W{1'b0}}) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] pend_cnt_r, pend_next_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_next_s;   // older writers the held branch still needs
    logic [CNT_W-1:0] sel_cnt_s;
    logic [2:0]       nzp_held_r, nzp_next_s;
    logic [2:0]       cc_r, wb_cc_s, cc_eff_s;
    logic             res_valid_r, res_valid_next_s;
    logic             res_taken_r, res_taken_next_s;
    logic             err_r, stall_r, ready_r;
    logic             bypass_s, inc_s, dec_s;

    assign wb_cc_s = derive_cc(cc_wb_data);
    assign inc_s   = cc_issue && (pend_cnt_r != CNT_MAX);
    assign dec_s   = cc_wb_valid && (pend_cnt_r != CNT_ZERO);

    // Outstanding-writer count; a full counter ignores issue even alongside a writeback.
    always_comb begin
        pend_next_s = pend_cnt_r;
        if (inc_s && !dec_s) begin
            pend_next_s = pend_cnt_r + CNT_ONE;
        end else if (dec_s && !inc_s) begin
            pend_next_s = pend_cnt_r - CNT_ONE;
        end else begin
            pend_next_s = pend_cnt_r;
        end
    end

    // Select the CC a resolving branch sees: the same-cycle final writeback when bypassing.
    always_comb begin
        sel_cnt_s = (state_r == ST_WAIT) ? wait_cnt_r : pend_cnt_r;
        bypass_s  = 1'b0;
        if ((BYPASS != 0) && (sel_cnt_s == CNT_ONE) && cc_wb_valid) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
        cc_eff_s = bypass_s ? wb_cc_s : cc_r;
    end

    // Branch FSM next state and result.
    always_comb begin
        state_s          = state_r;
        wait_next_s      = wait_cnt_r;
        nzp_next_s       = nzp_held_r;
        res_valid_next_s = 1'b0;
        res_taken_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (br_valid) begin
                    nzp_next_s = br_nzp;
                    if ((br_nzp == 3'b111) || (br_nzp == 3'b000) ||
                        (pend_cnt_r == CNT_ZERO) || bypass_s) begin
                        state_s          = ST_RESP;
                        res_valid_next_s = 1'b1;
                        res_taken_next_s = |(cc_eff_s & br_nzp);
                    end else begin
                        state_s     = ST_WAIT;
                        wait_next_s = cc_wb_valid ? (pend_cnt_r - CNT_ONE) : pend_cnt_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if ((wait_cnt_r == CNT_ZERO) || bypass_s) begin
                    state_s          = ST_RESP;
                    res_valid_next_s = 1'b1;
                    res_taken_next_s = |(cc_eff_s & nzp_held_r);
                end else if (cc_wb_valid) begin
                    wait_next_s = wait_cnt_r - CNT_ONE;
                end else begin
                    wait_next_s = wait_cnt_r;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, condition code and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pend_cnt_r  <= CNT_ZERO;
            wait_cnt_r  <= CNT_ZERO;
            nzp_held_r  <= 3'b000;
            cc_r        <= 3'b010;
            res_valid_r <= 1'b0;
            res_taken_r <= 1'b0;
            err_r       <= 1'b0;
            stall_r     <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            state_r     <= state_s;
            pend_cnt_r  <= pend_next_s;
            wait_cnt_r  <= wait_next_s;
            nzp_held_r  <= nzp_next_s;
            cc_r        <= cc_wb_valid ? wb_cc_s : cc_r;
            res_valid_r <= res_valid_next_s;
            res_taken_r <= res_taken_next_s;
            err_r       <= err_r | (cc_wb_valid && (pend_cnt_r == CNT_ZERO));
            stall_r     <= (pend_next_s == CNT_MAX);
            ready_r     <= (state_s == ST_IDLE);
        end
    end

    assign br_ready      = ready_r;
    assign br_res_valid  = res_valid_r;
    assign br_taken      = res_taken_r;
    assign cc            = cc_r;
    assign pend_cnt      = pend_cnt_r;
    assign issue_stall   = stall_r;
    assign err_underflow = err_r;

endmodule

// File: tb/tb_nzp_branch_unit.sv
// Bench for nzp_branch_unit: directed vector table, reset-mid-wait sequence,
// then random traffic against a counter/flag reference model.
module tb_nzp_branch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cc_issue, cc_wb_valid, br_valid;
    logic [15:0] cc_wb_data;
    logic [2:0]  br_nzp;
    logic        br_ready, br_res_valid, br_taken, issue_stall, err_underflow;
    logic [2:0]  cc;
    logic [2:0]  pend_cnt;

    int n_vec = 0;
    int n_err = 0;

    nzp_branch_unit #(.DATA_W(16), .MAX_PEND(4), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cc_issue(cc_issue), .cc_wb_valid(cc_wb_valid), .cc_wb_data(cc_wb_data),
        .br_valid(br_valid), .br_nzp(br_nzp), .br_ready(br_ready),
        .br_res_valid(br_res_valid), .br_taken(br_taken), .cc(cc),
        .pend_cnt(pend_cnt), .issue_stall(issue_stall), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // outputs packed as {rdy, rv, tk, cc[2:0], pend[2:0], stall, err}
    typedef struct {
        logic        issue;
        logic        wb;
        logic [15:0] data;
        logic        brv;
        logic [2:0]  nzp;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic issue, input logic wb, input logic [15:0] data,
                                input logic brv, input logic [2:0] nzp,
                                input logic rdy, input logic rv, input logic tk,
                                input logic [2:0] ccv, input logic [2:0] p,
                                input logic st, input logic er);
        vec_t v;
        v.issue = issue; v.wb = wb; v.data = data; v.brv = brv; v.nzp = nzp;
        v.exp = {rdy, rv, tk, ccv, p, st, er};
        return v;
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = {br_ready, br_res_valid, br_taken, cc, pend_cnt, issue_stall, err_underflow};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {rdy,rv,tk,cc,pend,stall,err}=%b required %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic issue, input logic wb, input logic [15:0] data,
                         input logic brv, input logic [2:0] nzp);
        cc_issue = issue; cc_wb_valid = wb; cc_wb_data = data; br_valid = brv; br_nzp = nzp;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 3'b000);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // reference model state: counts and flags derived from the rules, not the FSM
    int         m_pend, m_older;
    logic [2:0] m_cc, m_mask;
    bit         m_err, m_busy, m_resp, m_tk;

    task automatic model_reset();
        m_pend = 0; m_older = 0; m_cc = 3'b010; m_mask = 3'b000;
        m_err = 0; m_busy = 0; m_resp = 0; m_tk = 0;
    endtask

    task automatic model_step(input logic issue, input logic wb, input logic [15:0] data,
                              input logic brv, input logic [2:0] nzp);
        logic [2:0] wcc, ccx, mask;
        int cnt;
        bit resolve;
        wcc = ($signed(data) < 0) ? 3'b100 : ((data == 16'h0000) ? 3'b010 : 3'b001);
        resolve = 0; cnt = 0; mask = 3'b000; m_tk = 0;
        if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (m_older == 0 || (m_older == 1 && wb)) begin
                resolve = 1; cnt = m_older; mask = m_mask;
            end else if (wb) begin
                m_older = m_older - 1;
            end
        end else if (brv) begin
            if (nzp == 3'b111 || nzp == 3'b000 || m_pend == 0 || (m_pend == 1 && wb)) begin
                resolve = 1; cnt = m_pend; mask = nzp;
            end else begin
                m_busy = 1; m_mask = nzp; m_older = m_pend - (wb ? 1 : 0);
            end
        end
        if (resolve) begin
            ccx = (wb && cnt == 1) ? wcc : m_cc;
            m_tk = ((ccx & mask) != 3'b000);
            m_resp = 1; m_busy = 0;
        end
        if (wb && m_pend == 0) m_err = 1;
        if (issue && m_pend < 4) begin
            if (!(wb && m_pend > 0)) m_pend = m_pend + 1;
        end else if (wb && m_pend > 0) begin
            m_pend = m_pend - 1;
        end
        if (wb) m_cc = wcc;
    endtask

    function automatic logic [10:0] model_exp();
        logic [2:0] p;
        p = 3'(m_pend);
        return {!m_busy && !m_resp, m_resp, m_tk, m_cc, p, (m_pend == 4), m_err};
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 3'b000);
        // issue wb data brv nzp | rdy rv tk cc pend stall err
        tbl.push_back(mk(0,0,16'h0000,1,3'b010, 0,1,1,3'b010,3'd0,0,0)); // branch z at reset cc
        tbl.push_back(mk(0,0,16'h0000,0,3'b000, 1,0,0,3'b010,3'd0,0,0));
        tbl.push_back(mk(1,0,16'h0000,0,3'b000, 1,0,0,3'b010,3'd1,0,0));
        tbl.push_back(mk(0,0,16'h0000,1,3'b100, 0,0,0,3'b010,3'd1,0,0)); // waits
        tbl.push_back(mk(0,1,16'h8000,0,3'b000, 0,1,1,3'b100,3'd0,0,0)); // bypass resolve
        tbl.push_back(mk(0,0,16'h0000,0,3'b000, 1,0,0,3'b100,3'd0,0,0));
        tbl.push_back(mk(1,0,16'h0000,0,3'b000, 1,0,0,3'b100,3'd1,0,0));
        tbl.push_back(mk(1,0,16'h0000,0,3'b000, 1,0,0,3'b100,3'd2,0,0));
        tbl.push_back(mk(1,0,16'h0000,0,3'b000, 1,0,0,3'b100,3'd3,0,0));
        tbl.push_back(mk(1,0,16'h0000,0,3'b000, 1,0,0,3'b100,3'd4,1,0)); // full
        tbl.push_back(mk(1,0,16'h0000,0,3'b000, 1,0,0,3'b100,3'd4,1,0)); // saturates
        tbl.push_back(mk(1,1,16'h0001,0,3'b000, 1,0,0,3'b001,3'd3,0,0)); // issue+wb at full
        tbl.push_back(mk(0,1,16'h0000,0,3'b000, 1,0,0,3'b010,3'd2,0,0));
        tbl.push_back(mk(0,0,16'h0000,1,3'b111, 0,1,1,3'b010,3'd2,0,0)); // unconditional
        tbl.push_back(mk(0,0,16'h0000,0,3'b000, 1,0,0,3'b010,3'd2,0,0));
        tbl.push_back(mk(0,0,16'h0000,1,3'b000, 0,1,0,3'b010,3'd2,0,0)); // never
        tbl.push_back(mk(0,0,16'h0000,0,3'b000, 1,0,0,3'b010,3'd2,0,0));
        tbl.push_back(mk(1,0,16'h0000,1,3'b001, 0,0,0,3'b010,3'd3,0,0)); // younger issue
        tbl.push_back(mk(0,1,16'h0003,0,3'b000, 0,0,0,3'b001,3'd2,0,0));
        tbl.push_back(mk(1,0,16'h0000,0,3'b000, 0,0,0,3'b001,3'd3,0,0));
        tbl.push_back(mk(0,1,16'h7fff,0,3'b000, 0,1,1,3'b001,3'd2,0,0)); // last older wb
        tbl.push_back(mk(0,0,16'h0000,0,3'b000, 1,0,0,3'b001,3'd2,0,0));
        tbl.push_back(mk(0,1,16'h0000,0,3'b000, 1,0,0,3'b010,3'd1,0,0));
        tbl.push_back(mk(0,1,16'h8001,0,3'b000, 1,0,0,3'b100,3'd0,0,0));
        tbl.push_back(mk(0,1,16'h0005,0,3'b000, 1,0,0,3'b001,3'd0,0,1)); // underflow
        tbl.push_back(mk(0,0,16'h0000,0,3'b000, 1,0,0,3'b001,3'd0,0,1));
        tbl.push_back(mk(0,0,16'h0000,1,3'b100, 0,1,0,3'b001,3'd0,0,1)); // not taken
        tbl.push_back(mk(0,0,16'h0000,0,3'b000, 1,0,0,3'b001,3'd0,0,1));

        do_reset();
        check("reset_state", {1'b1, 1'b0, 1'b0, 3'b010, 3'd0, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            drive(tbl[i].issue, tbl[i].wb, tbl[i].data, tbl[i].brv, tbl[i].nzp);
            @(posedge clk);
            #1 check($sformatf("table_%0d", i), tbl[i].exp);
        end

        // reset while a branch is held: no result pulse afterwards
        do_reset();
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 3'b000);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 16'h0000, 1'b1, 3'b010);
        @(posedge clk);
        #1 check("wait_before_reset", {1'b0, 1'b0, 1'b0, 3'b010, 3'd1, 1'b0, 1'b0});
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 3'b000);
        rst_n = 1'b0;
        #1 check("async_reset_mid_wait", {1'b1, 1'b0, 1'b0, 3'b010, 3'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check($sformatf("no_pulse_after_reset_%0d", k),
                     {1'b1, 1'b0, 1'b0, 3'b010, 3'd0, 1'b0, 1'b0});
        end

        // random traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic issue, wb, brv;
            logic [15:0] data;
            logic [2:0] nzp;
            issue = ($urandom_range(99) < 40);
            wb    = (m_pend > 0) ? ($urandom_range(99) < 45) : ($urandom_range(99) < 2);
            case ($urandom_range(3))
                0: data = 16'h0000;
                1: data = 16'h8000 | 16'($urandom_range(16'h7fff));
                default: data = 16'($urandom_range(16'hffff));
            endcase
            brv = ($urandom_range(99) < 50);
            nzp = 3'($urandom_range(7));
            drive(issue, wb, data, brv, nzp);
            model_step(issue, wb, data, brv, nzp);
            @(posedge clk);
            #1 check($sformatf("random_%0d", c), model_exp());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
